// File: rtl/circ_queue_seq.sv
// circ_queue_seq: circular stereo sample window that replays its DEPTH newest
// samples oldest-first, one per clk, behind a registered synchronous RAM read.
module circ_queue_seq #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1021
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrt_smpl,
  input  logic [WIDTH-1:0] lft_in,
  input  logic [WIDTH-1:0] rght_in,
  output logic [WIDTH-1:0] lft_out,
  output logic [WIDTH-1:0] rght_out,
  output logic             sequencing,
  output logic             full,
  output logic             overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, SEQ} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] new_ptr_q, new_ptr_d, rd_ptr_q, rd_ptr_d, idx_q, idx_d, new_inc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [2*WIDTH-1:0] ram_q, out_q;
  logic v_q, seq_q, ovr_q, ovr_d, last, accept, start;
  always_comb begin
    new_inc   = new_ptr_q == LAST ? '0 : new_ptr_q + AW'(1);
    last      = state_q == SEQ && idx_q == LAST;
    accept    = state_q == IDLE || last;
    cnt_d     = wrt_smpl && cnt_q != FULLC ? cnt_q + CW'(1) : cnt_q;
    new_ptr_d = wrt_smpl ? new_inc : new_ptr_q;
    start     = wrt_smpl && accept && cnt_d == FULLC;
    ovr_d     = ovr_q | (wrt_smpl & ~accept);
    // a trigger landing on the final replay cycle waits one cycle so bursts never merge
    state_d   = start ? (state_q == SEQ ? WAIT : SEQ) :
                state_q == WAIT ? SEQ : last ? IDLE : state_q;
    rd_ptr_d  = start ? new_inc :
                state_q == SEQ ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;
    idx_d     = state_q == SEQ && !last ? idx_q + AW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (wrt_smpl) mem[new_ptr_q] <= {lft_in, rght_in};
    ram_q <= mem[rd_ptr_q];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      new_ptr_q <= '0;
      rd_ptr_q  <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      v_q       <= 1'b0;
      seq_q     <= 1'b0;
      ovr_q     <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      new_ptr_q <= new_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      v_q       <= state_q == SEQ;
      seq_q     <= v_q;
      ovr_q     <= ovr_d;
      out_q     <= v_q ? ram_q : out_q;
    end
  end
  assign {lft_out, rght_out} = out_q;
  assign sequencing = seq_q;
  assign full       = cnt_q == FULLC;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_circ_queue_seq.sv
// tb_circ_queue_seq: directed bench for circ_queue_seq with a cycle-scheduled
// reference model of the replay windows checked every cycle.
module tb_circ_queue_seq;
  localparam int D = 8;
  logic clk = 0, rst = 1, wrt = 0;
  logic [15:0] li = 0, ri = 0;
  logic [15:0] lft_out, rght_out;
  logic sequencing, full, overrun;
  int total = 0, bad = 0, rises = 0, r0;
  logic prev_seq = 0;
  logic [15:0] gl [D];
  logic [15:0] gr [D];
  circ_queue_seq #(.WIDTH(16), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .wrt_smpl(wrt), .lft_in(li), .rght_in(ri),
    .lft_out(lft_out), .rght_out(rght_out), .sequencing(sequencing),
    .full(full), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask
  // model: each accepted trigger schedules its window contents onto absolute cycle numbers
  int cyc = 0, last_edge = -1, mcnt = 0, s;
  logic [31:0] hist [$];
  logic [31:0] sched [int];
  logic m_seq = 0, m_ovr = 0;
  logic [15:0] m_l = 0, m_r = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt = 0; hist.delete(); sched.delete(); last_edge = -1;
      m_seq = 0; m_ovr = 0; m_l = 0; m_r = 0;
    end else begin
      cyc++;
      if (wrt) begin
        hist.push_back({li, ri});
        if (hist.size() > D) void'(hist.pop_front());
        if (mcnt < D) mcnt++;
        if (mcnt == D) begin
          if (cyc >= last_edge) begin
            s = (cyc == last_edge) ? cyc + 2 : cyc + 1;
            for (int k = 0; k < D; k++) sched[s + 1 + k] = hist[k];
            last_edge = s + D - 1;
          end else m_ovr = 1;
        end
      end
      m_seq = sched.exists(cyc);
      if (m_seq) {m_l, m_r} = sched[cyc];
    end
  end
  always @(negedge clk) begin
    chk("seq", sequencing, m_seq);
    chk("full", full, mcnt == D);
    chk("ovr", overrun, m_ovr);
    chk("lft", lft_out, m_l);
    chk("rght", rght_out, m_r);
    if (sequencing && !prev_seq) rises++;
    prev_seq = sequencing;
  end
  task automatic wr(input logic [15:0] l, input logic [15:0] r);
    @(posedge clk); #2 wrt = 1; li = l; ri = r;
    @(posedge clk); #2 wrt = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic grab();
    int k = 0;
    @(negedge clk); #1;
    while (!sequencing && k < 10) begin k++; @(negedge clk); #1; end
    chk("lat", k, 2);
    for (int i = 0; i < D; i++) begin
      gl[i] = lft_out; gr[i] = rght_out;
      chk("burst_seq", sequencing, 1);
      @(negedge clk); #1;
    end
    chk("burst_end", sequencing, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout got=running want=done");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seq", sequencing, 0); chk("rst_lft", lft_out, 0);
    chk("rst_full", full, 0); chk("rst_ovr", overrun, 0);
    #1 rst = 0;
    for (int v = 1; v <= 7; v++) begin wr(16'(v), 16'(v)); idle(19); end
    chk("fill_full", full, 0); chk("fill_rises", rises, 0);
    wr(16'd8, 16'd8);
    grab();
    chk("full8", full, 1);
    for (int k = 0; k < D; k++) begin
      chk("b8_l", gl[k], 16'(k + 1)); chk("b8_r", gr[k], 16'(k + 1));
    end
    idle(8);
    for (int v = 9; v <= 28; v++) begin
      wr(16'(v), 16'(v));
      grab();
      for (int k = 0; k < D; k++) chk("win_l", gl[k], 16'(v - 7 + k));
      if (v == 9) begin chk("w9_first", gl[0], 16'd2); chk("w9_last", gr[7], 16'd9); end
      idle(8);
    end
    r0 = rises;
    wr(16'd29, 16'd29);
    fork
      grab();
      begin idle(3); #2 wrt = 1; li = 16'd30; ri = 16'd30; @(posedge clk); #2 wrt = 0; end
    join
    for (int k = 0; k < D; k++) chk("ovr_burst", gl[k], 16'(22 + k));
    chk("ovr_flag", overrun, 1);
    idle(25);
    chk("ovr_noextra", rises, r0 + 1);
    wr(16'd31, 16'd31);
    grab();
    for (int k = 0; k < D; k++) chk("after_ovr", gl[k], 16'(24 + k));
    idle(8);
    wr(16'd32, 16'd32);
    begin
      int k = 0;
      @(negedge clk);
      while (!sequencing && k < 10) begin k++; @(negedge clk); end
      chk("rst_lat", k, 2);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("mid_rst_seq", sequencing, 0); chk("mid_rst_l", lft_out, 0);
    chk("mid_rst_r", rght_out, 0); chk("mid_rst_full", full, 0);
    idle(2); #2 rst = 0;
    r0 = rises;
    for (int v = 33; v <= 39; v++) begin wr(16'(v), 16'(v)); idle(19); end
    chk("refill_full", full, 0); chk("refill_rises", rises, r0);
    wr(16'd40, 16'd40);
    grab();
    for (int k = 0; k < D; k++) chk("refill_burst", gl[k], 16'(33 + k));
    idle(8);
    for (int i = 0; i < D; i++) begin
      wr(16'h8000 + 16'(i), 16'h7FFF - 16'(i));
      grab();
      idle(8);
    end
    for (int k = 0; k < D; k++) begin
      chk("ch_l", gl[k], 16'h8000 + 16'(k)); chk("ch_r", gr[k], 16'h7FFF - 16'(k));
    end
    r0 = rises;
    wr(16'h1234, 16'h4321);
    idle(7); #2 wrt = 1; li = 16'h5555; ri = 16'hAAAA;
    @(posedge clk); #2 wrt = 0;
    idle(30);
    chk("edge_rises", rises, r0 + 2);
    chk("edge_ovr", overrun, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
